// File: rtl/pulse_width_decoder.sv
// Synchronizes a stretched pulse, measures its high time and flags short pulses and stuck lines.
// Optional PULSE_WIDTH_DECODER_LEAD_EN adds pulseLead, a strobe when a pulse first reaches the minimum width.
module pulse_width_decoder #(
    parameter int CLK_FREQUENCY = 100000000,
    parameter int MIN_WIDTH_US  = 10,
    parameter int MAX_WIDTH_MS  = 150,
    parameter int SYNC_STAGES   = 2,
    localparam int MIN_CYCLES   = $rtoi(CLK_FREQUENCY / 1.0e6 * MIN_WIDTH_US),
    localparam int MAX_CYCLES   = $rtoi(CLK_FREQUENCY / 1.0e3 * MAX_WIDTH_MS),
    localparam int CW           = $clog2(MAX_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pulseIn,
    output logic          pulseDetect,
    output logic [CW-1:0] pulseWidth,
    output logic          glitch,
    output logic          stuckHigh,
`ifdef PULSE_WIDTH_DECODER_LEAD_EN
    output logic          pulseLead,
`endif
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, MEASURE, STUCK} state_t;

    state_t               state, stateNext;
    logic [SYNC_STAGES-1:0] syncChain;
    logic                 s;
    logic [CW-1:0]        counter, counterNext, widthNext;
    logic                 detectNext, glitchNext, stuckNext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncChain <= '0;
        end else begin
            syncChain <= {syncChain[SYNC_STAGES-2:0], pulseIn};
        end
    end

    assign s    = syncChain[SYNC_STAGES-1];
    assign busy = (state == MEASURE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            counter     <= '0;
            pulseDetect <= 1'b0;
            pulseWidth  <= '0;
            glitch      <= 1'b0;
            stuckHigh   <= 1'b0;
        end else begin
            state       <= stateNext;
            counter     <= counterNext;
            pulseDetect <= detectNext;
            pulseWidth  <= widthNext;
            glitch      <= glitchNext;
            stuckHigh   <= stuckNext;
        end
    end

    always_comb begin
        stateNext   = state;
        counterNext = counter;
        widthNext   = pulseWidth;
        detectNext  = 1'b0;
        glitchNext  = 1'b0;
        stuckNext   = stuckHigh;
        case (state)
            IDLE: begin
                if (s) begin
                    stateNext   = MEASURE;
                    counterNext = CW'(1);
                end
            end
            MEASURE: begin
                if (s) begin
                    // Saturate at MAX_CYCLES and park in STUCK until the line releases.
                    if (counter == CW'(MAX_CYCLES - 1)) begin
                        counterNext = CW'(MAX_CYCLES);
                        stuckNext   = 1'b1;
                        stateNext   = STUCK;
                    end else begin
                        counterNext = counter + CW'(1);
                    end
                end else begin
                    if (counter >= CW'(MIN_CYCLES)) begin
                        detectNext = 1'b1;
                        widthNext  = counter;
                    end else begin
                        glitchNext = 1'b1;
                    end
                    stateNext = IDLE;
                end
            end
            STUCK: begin
                if (!s) begin
                    stuckNext = 1'b0;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

`ifdef PULSE_WIDTH_DECODER_LEAD_EN
    logic leadNext;

    // Fires on the cycle the count first reaches MIN_CYCLES; with MIN_CYCLES==1 that is the capture from IDLE.
    assign leadNext = s && (((state == IDLE) && (MIN_CYCLES == 1)) ||
                            ((state == MEASURE) && (counter == CW'(MIN_CYCLES - 1))));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulseLead <= 1'b0;
        end else begin
            pulseLead <= leadNext;
        end
    end
`endif

endmodule

// File: tb/tb_pulse_width_decoder.sv
// Scoreboard bench for pulse_width_decoder: directed pulses push expected strobes/levels, a monitor checks them.
module tb_pulse_width_decoder;

    localparam int MIN = 5;
    localparam int MAX = 1000;
    localparam int CW  = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pulseIn = 1'b0;
    logic          pulseDetect;
    logic [CW-1:0] pulseWidth;
    logic          glitch;
    logic          stuckHigh;
    logic          busy;
`ifdef PULSE_WIDTH_DECODER_LEAD_EN
    logic          pulseLead;
`endif

    pulse_width_decoder #(
        .CLK_FREQUENCY(1000000),
        .MIN_WIDTH_US (5),
        .MAX_WIDTH_MS (1),
        .SYNC_STAGES  (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pulseIn    (pulseIn),
        .pulseDetect(pulseDetect),
        .pulseWidth (pulseWidth),
        .glitch     (glitch),
        .stuckHigh  (stuckHigh),
`ifdef PULSE_WIDTH_DECODER_LEAD_EN
        .pulseLead  (pulseLead),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int kind;
        int val;
    } exp_t;

    exp_t evQ[$];
    exp_t busyQ[$];
    exp_t stuckQ[$];

    int total = 0;
    int bad   = 0;
    int leadTotal = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples 1ns after each rising edge.
    initial begin
        exp_t e;
        logic prevBusy  = 1'b0;
        logic prevStuck = 1'b0;
        int   busyRise  = 0;
        int   stuckRise = 0;
        int   leadCnt   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (pulseDetect || glitch) begin
                if (evQ.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    e = evQ.pop_front();
                    check("strobe_cycle", cyc, e.cyc);
                    check("strobe_kind", int'(glitch), e.kind);
                    check("strobe_exclusive", int'(pulseDetect && glitch), 0);
                    check("pulse_width", int'(pulseWidth), e.val);
                end
            end
            if (busy && !prevBusy) begin
                busyRise = cyc;
                leadCnt  = 0;
            end
            if (!busy && prevBusy) begin
                if (busyQ.size() == 0) begin
                    check("unexpected_busy", 1, 0);
                end else begin
                    e = busyQ.pop_front();
                    check("busy_rise", busyRise, e.cyc);
                    check("busy_len", cyc - busyRise, e.val);
                end
            end
            if (stuckHigh && !prevStuck) stuckRise = cyc;
            if (!stuckHigh && prevStuck) begin
                if (stuckQ.size() == 0) begin
                    check("unexpected_stuck", 1, 0);
                end else begin
                    e = stuckQ.pop_front();
                    check("stuck_rise", stuckRise, e.cyc);
                    check("stuck_len", cyc - stuckRise, e.val);
                end
            end
`ifdef PULSE_WIDTH_DECODER_LEAD_EN
            if (pulseLead) begin
                leadCnt++;
                leadTotal++;
                check("lead_busy", int'(busy), 1);
                check("lead_age", cyc - busyRise, MIN - 1);
                check("lead_once", leadCnt, 1);
            end
`endif
            prevBusy  = busy;
            prevStuck = stuckHigh;
        end
    end

    // Directed pulses: high cycles, low gap, outcome (0 detect, 1 glitch, 2 stuck), expected pulseWidth.
    int tN[8]     = '{20, 4, 5, 3, 1500, 8, 10, 7};
    int tLow[8]   = '{10, 10, 10, 10, 10, 10, 1, 10};
    int tKind[8]  = '{0, 1, 0, 1, 2, 0, 0, 0};
    int tWidth[8] = '{20, 20, 5, 5, 5, 8, 10, 7};

    initial begin
        int rise;
        repeat (3) @(negedge clk);
        check("rst_detect", int'(pulseDetect), 0);
        check("rst_width", int'(pulseWidth), 0);
        check("rst_glitch", int'(glitch), 0);
        check("rst_stuck", int'(stuckHigh), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            rise    = cyc;
            pulseIn = 1'b1;
            if (tKind[i] == 2) begin
                busyQ.push_back('{rise + 3, 0, MAX - 1});
                stuckQ.push_back('{rise + 2 + MAX, 0, tN[i] + 1 - MAX});
            end else begin
                busyQ.push_back('{rise + 3, 0, tN[i]});
            end
            repeat (tN[i]) @(negedge clk);
            pulseIn = 1'b0;
            if (tKind[i] != 2) evQ.push_back('{cyc + 3, tKind[i], tWidth[i]});
            repeat (tLow[i]) @(negedge clk);
        end

        // Reset in the middle of a 50-cycle pulse; the tail after release is measured fresh.
        rise    = cyc;
        pulseIn = 1'b1;
        busyQ.push_back('{rise + 3, 0, 18});
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_width", int'(pulseWidth), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_stuck", int'(stuckHigh), 0);
        rst_n = 1'b1;
        busyQ.push_back('{rise + 26, 0, 27});
        repeat (27) @(negedge clk);
        pulseIn = 1'b0;
        evQ.push_back('{cyc + 3, 0, 27});

        repeat (12) @(negedge clk);
        check("events_drained", evQ.size(), 0);
        check("busy_drained", busyQ.size(), 0);
        check("stuck_drained", stuckQ.size(), 0);
        check("final_width", int'(pulseWidth), 27);
`ifdef PULSE_WIDTH_DECODER_LEAD_EN
        check("lead_total", leadTotal, 8);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
